// File: rtl/mdu_ctrl.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO; optional MDU_FAST_MUL_EN single-cycle multiply.
// Latency: 34 edges accept-to-result for iterative ops (2 for multiply with MDU_FAST_MUL_EN), 1 for MTHI/MTLO.
// Backpressure: req_ready only in IDLE without flush; busy holds EXE for the whole op; flush aborts without commit.
module mdu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Shared work register: {acc_hi, multiplier} for multiply, {rem, quot} for divide.
  logic [63:0] acc_q, acc_d;
  // Multiplicand magnitude or divisor magnitude.
  logic [31:0] opb_q, opb_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        accept;
  logic        op_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_trial;
  logic [63:0] div_step;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  assign req_ready = (state_q == S_IDLE) & ~flush;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign accept    = req_valid & req_ready;

  // Operand magnitudes, one iteration of each algorithm, and the sign fixup seen in FIN.
  always_comb begin
    op_signed = ~op[0];
    mag_a     = (op_signed & src_a[31]) ? (~src_a + 32'd1) : src_a;
    mag_b     = (op_signed & src_b[31]) ? (~src_b + 32'd1) : src_b;

    // Shift-add: conditionally add multiplicand to the upper half, then shift right.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_step  = {mul_sum, acc_q[31:1]};

    // Restoring divide: trial-subtract the divisor from the shifted remainder.
    div_trial = acc_q[63:31] - {1'b0, opb_q};
    div_step  = div_trial[32] ? {acc_q[62:0], 1'b0}
                              : {div_trial[31:0], acc_q[30:0], 1'b1};

    prod      = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    // A zero divisor leaves rem = |dividend|, so the remainder fixup restores the raw dividend.
    if (is_div_q) begin
      res_hi = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
      if (div0_q)
        res_lo = 32'hFFFF_FFFF;
      else
        res_lo = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // Next-state, datapath and HI/LO update; flush overrides everything at the end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!op[2]) begin
            is_div_d  = op[1];
            neg_res_d = op_signed & (src_a[31] ^ src_b[31]);
            neg_rem_d = op_signed & src_a[31];
            div0_d    = op[1] & (src_b == 32'd0);
            cnt_d     = 5'd0;
            state_d   = S_CALC;
            if (op[1]) begin
              acc_d = {32'd0, mag_a};
              opb_d = mag_b;
            end else begin
`ifdef MDU_FAST_MUL_EN
              acc_d   = {32'd0, mag_a} * {32'd0, mag_b};
              opb_d   = mag_a;
              state_d = S_FIN;
`else
              acc_d = {32'd0, mag_b};
              opb_d = mag_a;
`endif
            end
          end else begin
            // MTHI/MTLO commit at the accept edge; reserved ops only acknowledge.
            if (op == 3'b100) hi_d = src_a;
            if (op == 3'b101) lo_d = src_a;
            done_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIN;
      end
      S_FIN: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // FSM state and iteration counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath, sign flags and architectural HI/LO with the done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Purpose: self-checking bench for mdu_ctrl against an arithmetic reference of HI/LO semantics.
// Latency: expects 34 edges for iterative ops (2 for multiply with MDU_FAST_MUL_EN), 1 for MTHI/MTLO.
// Backpressure: exercises flush abort, flush-vs-request priority and mid-operation reset.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nchecks = 0;
  int nerrors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference semantics: returns {hi, lo} after the op, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_mdu(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2, 3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o);
    if (o[2]) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!o[1]) return 2;
`endif
    return 34;
  endfunction

  // Called at the negedge right after the accept edge; waits for done and checks everything.
  task automatic finish_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
    int n;
    bit busy_bad;
    logic [63:0] exp;
    exp = ref_mdu(o, a, b, m_hi, m_lo);
    src_a = $urandom;
    src_b = $urandom;
    n = 1;
    busy_bad = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy !== 1'b1) busy_bad = 1;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_latency(o)));
    check({tag, " busy during op"}, 64'(busy_bad), 64'd0);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    check({tag, " busy after"}, {63'd0, busy}, 64'd0);
    check({tag, " ready after"}, {63'd0, req_ready}, 64'd1);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(negedge clk);
    check({tag, " done one cycle"}, {63'd0, done}, 64'd0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    issue(o, a, b);
    finish_op(o, a, b, tag);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    // Reset state
    #3;
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    // Directed arithmetic cases
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div neg by 2");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult -1*-1");
    run_op(3'd3, 32'h1234_5678, 32'h0000_0000, "divu by zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, "div neg by zero");

    // MTHI while idle: next-cycle value, one-cycle done, never busy
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, "mthi");
    run_op(3'd6, 32'h5555_5555, 32'd0, "reserved op");

    // Flush during CALC
    run_op(3'd4, 32'h1111_1111, 32'd0, "mthi preload");
    run_op(3'd5, 32'h1111_1111, 32'd0, "mtlo preload");
    issue(3'd2, 32'h0000_1234, 32'h0000_0011);
    repeat (9) @(negedge clk);
    check("calc still busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    req_valid = 1'b1;
    op = 3'd3;
    src_a = 32'd1000;
    src_b = 32'd9;
    @(negedge clk);
    check("flush busy drop", {63'd0, busy}, 64'd0);
    check("flush hi kept", {32'd0, hi}, 64'h1111_1111);
    check("flush lo kept", {32'd0, lo}, 64'h1111_1111);
    check("flush no done", {63'd0, done}, 64'd0);
    check("flush blocks ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check("flush no accept", {63'd0, busy}, 64'd0);
    check("flush no late done", {63'd0, done}, 64'd0);
    flush = 1'b0;
    #1;
    check("ready after flush", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    finish_op(3'd3, 32'd1000, 32'd9, "divu after flush");

    // Reset in the middle of CALC
    issue(3'd1, 32'h0001_0003, 32'h0002_0005);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset hi", {32'd0, hi}, 64'd0);
    check("midreset lo", {32'd0, lo}, 64'd0);
    check("midreset done", {63'd0, done}, 64'd0);
    check("midreset busy", {63'd0, busy}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    run_op(3'd3, 32'd100, 32'd7, "divu 100/7");

    // Randomized ops, including back-to-back issue straight after done
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb, $sformatf("rand%0d op%0d", i, ro));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
